// File: rtl/mem_noc_arb_2to1.sv
// ---------------------------------------------------------------------------
// mem_noc_arb_2to1
//
// Merges two memory masters (m0 = instruction port, m1 = data port) onto a
// single mem NoC router master port. At most one transaction is outstanding
// at any time. The response always returns to the master that owns the
// outstanding transaction.
//
// Parameters
//   FIXED_PRIO : 0 = round-robin between masters, 1 = m0 always wins
//   REQ_W      : request payload width  (width of mem_req_t)
//   RESP_W     : response payload width (width of mem_resp_t)
//
// Ports
//   clk, rst                       : clock, synchronous active-high reset
//   m0_req_valid/ready/req         : master 0 request channel
//   m0_resp_valid/ready/resp       : master 0 response channel
//   m1_req_valid/ready/req         : master 1 request channel
//   m1_resp_valid/ready/resp       : master 1 response channel
//   mn_req_valid/ready/req         : merged request toward the router
//   mn_resp_valid/ready/resp       : response from the router
//
// Both request and response paths are combinational: a request can hand
// off in the same cycle the master raises valid, and a response reaches its
// owner with zero latency.
// ---------------------------------------------------------------------------
module mem_noc_arb_2to1 #(
   parameter int FIXED_PRIO = 0,
   parameter int REQ_W      = 32,
   parameter int RESP_W     = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic [REQ_W-1:0]  m0_req,
   output logic              m0_resp_valid,
   input  logic              m0_resp_ready,
   output logic [RESP_W-1:0] m0_resp,

   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic [REQ_W-1:0]  m1_req,
   output logic              m1_resp_valid,
   input  logic              m1_resp_ready,
   output logic [RESP_W-1:0] m1_resp,

   output logic              mn_req_valid,
   input  logic              mn_req_ready,
   output logic [REQ_W-1:0]  mn_req,
   input  logic              mn_resp_valid,
   output logic              mn_resp_ready,
   input  logic [RESP_W-1:0] mn_resp
);

   typedef enum logic [0:0] {
      ARB_REQ  = 1'b0,   // nothing outstanding
      ARB_RESP = 1'b1    // one transaction outstanding
   } arb_state_t;

   arb_state_t st_r;
   arb_state_t st_nxt_s;

   logic gnt_id_r;     // master owning the presented / pending request
   logic gnt_lock_r;   // request presented to router but not yet accepted
   logic rr_ptr_r;     // master that wins the next tie
   logic out_id_r;     // master owning the outstanding transaction

   logic sel_id_s;
   logic sel_valid_s;
   logic req_valid_s;
   logic req_hs_s;
   logic resp_hs_s;

   localparam logic FIXED_S = (FIXED_PRIO != 32'sd0);

   // Master selection: a locked grant is held so a presented request is
   // never retracted or swapped; otherwise single-valid wins, ties resolved
   // by priority mode.
   always_comb begin
      sel_id_s    = 1'b0;
      sel_valid_s = 1'b0;
      if (gnt_lock_r) begin
         sel_id_s    = gnt_id_r;
         sel_valid_s = gnt_id_r ? m1_req_valid : m0_req_valid;
      end else if (m0_req_valid && m1_req_valid) begin
         sel_id_s    = FIXED_S ? 1'b0 : rr_ptr_r;
         sel_valid_s = 1'b1;
      end else if (m0_req_valid) begin
         sel_id_s    = 1'b0;
         sel_valid_s = 1'b1;
      end else if (m1_req_valid) begin
         sel_id_s    = 1'b1;
         sel_valid_s = 1'b1;
      end else begin
         sel_id_s    = 1'b0;
         sel_valid_s = 1'b0;
      end
   end

   // Response routing: only meaningful while a transaction is outstanding;
   // a stray router response in ARB_REQ is ignored.
   always_comb begin
      mn_resp_ready = 1'b0;
      m0_resp_valid = 1'b0;
      m1_resp_valid = 1'b0;
      if (st_r == ARB_RESP) begin
         mn_resp_ready = out_id_r ? m1_resp_ready : m0_resp_ready;
         m0_resp_valid = mn_resp_valid & ~out_id_r;
         m1_resp_valid = mn_resp_valid &  out_id_r;
      end else begin
         mn_resp_ready = 1'b0;
         m0_resp_valid = 1'b0;
         m1_resp_valid = 1'b0;
      end
      resp_hs_s = mn_resp_valid & mn_resp_ready;
   end

   // Request issue and next-state: in ARB_RESP a new request may only go
   // out in the cycle the current response retires (back-to-back issue).
   always_comb begin
      req_valid_s = 1'b0;
      st_nxt_s    = st_r;
      case (st_r)
         ARB_REQ: begin
            req_valid_s = sel_valid_s;
            if (sel_valid_s && mn_req_ready) begin
               st_nxt_s = ARB_RESP;
            end else begin
               st_nxt_s = ARB_REQ;
            end
         end
         ARB_RESP: begin
            req_valid_s = sel_valid_s & resp_hs_s;
            if (resp_hs_s && !(req_valid_s && mn_req_ready)) begin
               st_nxt_s = ARB_REQ;
            end else begin
               st_nxt_s = ARB_RESP;
            end
         end
         default: begin
            req_valid_s = 1'b0;
            st_nxt_s    = ARB_REQ;
         end
      endcase
   end

   assign req_hs_s     = req_valid_s & mn_req_ready;
   assign mn_req_valid = req_valid_s;
   assign mn_req       = sel_id_s ? m1_req : m0_req;
   assign m0_req_ready = req_hs_s & ~sel_id_s;
   assign m1_req_ready = req_hs_s &  sel_id_s;
   assign m0_resp      = mn_resp;
   assign m1_resp      = mn_resp;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_r <= ARB_REQ;
      end else begin
         st_r <= st_nxt_s;
      end
   end

   // Grant bookkeeping: lock, owner of the presented request, owner of the
   // outstanding transaction and the round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_id_r   <= 1'b0;
         gnt_lock_r <= 1'b0;
         rr_ptr_r   <= 1'b0;
         out_id_r   <= 1'b0;
      end else begin
         if (req_valid_s) begin
            gnt_id_r <= sel_id_s;
         end
         if (req_hs_s) begin
            gnt_lock_r <= 1'b0;
            out_id_r   <= sel_id_s;
            if (!FIXED_S) begin
               rr_ptr_r <= ~sel_id_s;
            end
         end else if (req_valid_s) begin
            gnt_lock_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_noc_arb_2to1.sv
// Testbench for mem_noc_arb_2to1: randomized masters and router model with a
// scoreboard of expected responses per master, an independent monitor that
// checks arbitration rules every cycle, and a few directed scenarios
// (stalled owner, reset mid-transaction, fixed-priority starvation).
module tb_mem_noc_arb_2to1;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic         m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
   logic [W-1:0] m0_req, m0_resp;
   logic         m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
   logic [W-1:0] m1_req, m1_resp;
   logic         mn_req_valid, mn_req_ready, mn_resp_valid, mn_resp_ready;
   logic [W-1:0] mn_req, mn_resp;

   logic         f_m0_req_valid, f_m0_req_ready, f_m0_resp_valid, f_m0_resp_ready;
   logic [W-1:0] f_m0_req, f_m0_resp;
   logic         f_m1_req_valid, f_m1_req_ready, f_m1_resp_valid, f_m1_resp_ready;
   logic [W-1:0] f_m1_req, f_m1_resp;
   logic         f_mn_req_valid, f_mn_req_ready, f_mn_resp_valid, f_mn_resp_ready;
   logic [W-1:0] f_mn_req, f_mn_resp;

   mem_noc_arb_2to1 #(.FIXED_PRIO(0), .REQ_W(W), .RESP_W(W)) dut (
      .clk(clk), .rst(rst),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req(m0_req),
      .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req(m1_req),
      .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp),
      .mn_req_valid(mn_req_valid), .mn_req_ready(mn_req_ready), .mn_req(mn_req),
      .mn_resp_valid(mn_resp_valid), .mn_resp_ready(mn_resp_ready), .mn_resp(mn_resp)
   );

   mem_noc_arb_2to1 #(.FIXED_PRIO(1), .REQ_W(W), .RESP_W(W)) dut_fp (
      .clk(clk), .rst(rst),
      .m0_req_valid(f_m0_req_valid), .m0_req_ready(f_m0_req_ready), .m0_req(f_m0_req),
      .m0_resp_valid(f_m0_resp_valid), .m0_resp_ready(f_m0_resp_ready), .m0_resp(f_m0_resp),
      .m1_req_valid(f_m1_req_valid), .m1_req_ready(f_m1_req_ready), .m1_req(f_m1_req),
      .m1_resp_valid(f_m1_resp_valid), .m1_resp_ready(f_m1_resp_ready), .m1_resp(f_m1_resp),
      .mn_req_valid(f_mn_req_valid), .mn_req_ready(f_mn_req_ready), .mn_req(f_mn_req),
      .mn_resp_valid(f_mn_resp_valid), .mn_resp_ready(f_mn_resp_ready), .mn_resp(f_mn_resp)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Router memory transform: each response is a function of its request.
   function automatic logic [W-1:0] mem_fn(input logic [W-1:0] r);
      return {r[15:0], r[31:16]} ^ 32'h1234_5678;
   endfunction

   // Scoreboard: expected responses per master, in issue order.
   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];

   // Stimulus state: masters and router model.
   bit           busy0 = 1'b0, busy1 = 1'b0, gen_en = 1'b0;
   int           seq = 0;
   bit           r_pend = 1'b0;
   int           r_dly = 0;
   logic [W-1:0] r_resp = '0;

   task automatic drive_cycle();
      @(negedge clk);
      if (m0_req_valid && m0_req_ready) begin
         exp_q0.push_back(mem_fn(m0_req));
         busy0 = 1'b0;
      end
      if (m1_req_valid && m1_req_ready) begin
         exp_q1.push_back(mem_fn(m1_req));
         busy1 = 1'b0;
      end
      if (mn_resp_valid && mn_resp_ready) begin
         chk_bit("router_resp_taken_only_when_pending", r_pend, 1'b1);
         r_pend = 1'b0;
      end
      if (mn_req_valid && mn_req_ready) begin
         chk_bit("single_outstanding", r_pend, 1'b0);
         r_pend = 1'b1;
         r_dly  = $urandom_range(0, 3);
         r_resp = mem_fn(mn_req);
      end
      @(posedge clk);
      #1;
      if (!busy0 && gen_en && $urandom_range(0, 2) == 0) begin
         busy0 = 1'b1;
         seq++;
         m0_req = {1'b0, 15'(seq), 16'($urandom)};
      end
      if (!busy1 && gen_en && $urandom_range(0, 2) == 0) begin
         busy1 = 1'b1;
         seq++;
         m1_req = {1'b1, 15'(seq), 16'($urandom)};
      end
      m0_req_valid  = busy0;
      m1_req_valid  = busy1;
      m0_resp_ready = ($urandom_range(0, 3) != 0);
      m1_resp_ready = ($urandom_range(0, 3) != 0);
      mn_req_ready  = ($urandom_range(0, 2) != 0);
      if (r_pend) begin
         mn_resp_valid = (r_dly == 0);
         mn_resp       = r_resp;
         if (r_dly > 0) r_dly--;
      end else begin
         // Occasional stray router response while idle; must be ignored.
         mn_resp_valid = ($urandom_range(0, 9) == 0);
         mn_resp       = $urandom;
      end
   endtask

   // Monitor: reference view of the arbiter as "who owns what".
   bit           mo_out, mo_owner, mo_prio, mo_lock, mo_lock_id;
   logic         mo_v0, mo_v1, mo_ev, mo_eid, mo_erdy, mo_rhs;

   // Per-cycle protocol, arbitration and scoreboard checks.
   always @(negedge clk) begin
      if (rst) begin
         mo_out = 1'b0; mo_owner = 1'b0; mo_prio = 1'b0;
         mo_lock = 1'b0; mo_lock_id = 1'b0;
      end else begin
         mo_v0   = m0_req_valid;
         mo_v1   = m1_req_valid;
         mo_erdy = mo_out ? (mo_owner ? m1_resp_ready : m0_resp_ready) : 1'b0;
         chk_bit("mn_resp_ready", mn_resp_ready, mo_erdy);
         chk_bit("m0_resp_valid", m0_resp_valid, mo_out && mn_resp_valid && !mo_owner);
         chk_bit("m1_resp_valid", m1_resp_valid, mo_out && mn_resp_valid && mo_owner);
         chk_w("m0_resp_passthru", m0_resp, mn_resp);
         chk_w("m1_resp_passthru", m1_resp, mn_resp);
         mo_rhs = mo_out && mn_resp_valid && mo_erdy;
         if (mo_rhs) begin
            if (!mo_owner) begin
               if (exp_q0.size() == 0) begin
                  n_checks++; n_errors++;
                  $display("FAIL resp0_scoreboard: got response %h, required none pending", m0_resp);
               end else begin
                  chk_w("resp0_data", m0_resp, exp_q0.pop_front());
               end
            end else begin
               if (exp_q1.size() == 0) begin
                  n_checks++; n_errors++;
                  $display("FAIL resp1_scoreboard: got response %h, required none pending", m1_resp);
               end else begin
                  chk_w("resp1_data", m1_resp, exp_q1.pop_front());
               end
            end
         end
         if (mo_lock)          mo_eid = mo_lock_id;
         else if (mo_v0 && mo_v1) mo_eid = mo_prio;
         else                  mo_eid = mo_v1 && !mo_v0;
         mo_ev = (mo_v0 || mo_v1) && (!mo_out || mo_rhs);
         chk_bit("mn_req_valid", mn_req_valid, mo_ev);
         if (mo_ev) begin
            chk_w("mn_req_payload", mn_req, mo_eid ? m1_req : m0_req);
            chk_bit("m0_req_ready", m0_req_ready, !mo_eid && mn_req_ready);
            chk_bit("m1_req_ready", m1_req_ready, mo_eid && mn_req_ready);
         end else begin
            chk_bit("m0_req_ready_idle", m0_req_ready, 1'b0);
            chk_bit("m1_req_ready_idle", m1_req_ready, 1'b0);
         end
         if (mo_rhs) mo_out = 1'b0;
         if (mo_ev && mn_req_ready) begin
            mo_out = 1'b1; mo_owner = mo_eid; mo_prio = ~mo_eid; mo_lock = 1'b0;
         end else if (mo_ev) begin
            mo_lock = 1'b1; mo_lock_id = mo_eid;
         end
      end
   end

   initial begin
      int k;
      int g0, g1;
      bit fpend;
      rst = 1'b1;
      m0_req_valid = 1'b0; m0_req = '0; m0_resp_ready = 1'b0;
      m1_req_valid = 1'b0; m1_req = '0; m1_resp_ready = 1'b0;
      mn_req_ready = 1'b0; mn_resp_valid = 1'b0; mn_resp = '0;
      f_m0_req_valid = 1'b0; f_m0_req = '0; f_m0_resp_ready = 1'b0;
      f_m1_req_valid = 1'b0; f_m1_req = '0; f_m1_resp_ready = 1'b0;
      f_mn_req_ready = 1'b0; f_mn_resp_valid = 1'b0; f_mn_resp = '0;

      // Reset behaviour: stray response ignored, valid master still visible.
      repeat (2) @(posedge clk);
      #1;
      m0_req_valid = 1'b1; m0_req = 32'h0000_1111;
      mn_resp_valid = 1'b1; mn_resp = 32'hCAFE_0001;
      m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
      @(negedge clk);
      chk_bit("rst_mn_resp_ready", mn_resp_ready, 1'b0);
      chk_bit("rst_m0_resp_valid", m0_resp_valid, 1'b0);
      chk_bit("rst_m1_resp_valid", m1_resp_valid, 1'b0);
      chk_bit("rst_mn_req_valid", mn_req_valid, 1'b1);
      chk_w("rst_mn_req", mn_req, 32'h0000_1111);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m0_req_valid = 1'b0; mn_resp_valid = 1'b0;

      // Randomized traffic.
      gen_en = 1'b1;
      for (int i = 0; i < 2000; i++) drive_cycle();

      // Drain all traffic.
      gen_en = 1'b0;
      k = 0;
      while ((busy0 || busy1 || r_pend || exp_q0.size() != 0 || exp_q1.size() != 0) && k < 300) begin
         drive_cycle();
         k++;
      end
      chk_bit("drain_complete", busy0 || busy1 || r_pend, 1'b0);
      chk_w("drain_q0_empty", exp_q0.size(), 32'd0);
      chk_w("drain_q1_empty", exp_q1.size(), 32'd0);

      // m1 outstanding, its response stalled, m0 waiting.
      m0_req_valid = 1'b0; m1_req_valid = 1'b1; m1_req = 32'h8000_0042;
      mn_req_ready = 1'b1; mn_resp_valid = 1'b0;
      m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
      @(negedge clk);
      chk_bit("dir_m1_req_ready", m1_req_ready, 1'b1);
      chk_w("dir_mn_req_m1", mn_req, 32'h8000_0042);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         m1_req_valid = 1'b0; m0_req_valid = 1'b1; m0_req = 32'h0000_0077;
         mn_resp_valid = 1'b1; mn_resp = 32'hDEAD_BEEF; m1_resp_ready = 1'b0;
         @(negedge clk);
         chk_bit("stall_mn_resp_ready", mn_resp_ready, 1'b0);
         chk_bit("stall_m0_resp_valid", m0_resp_valid, 1'b0);
         chk_bit("stall_m0_req_ready", m0_req_ready, 1'b0);
         chk_bit("stall_mn_req_valid", mn_req_valid, 1'b0);
      end

      // Reset mid-transaction, then a late response arrives.
      @(posedge clk);
      #1;
      rst = 1'b1; m0_req_valid = 1'b0; mn_resp_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0; mn_resp_valid = 1'b1; m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
      @(negedge clk);
      chk_bit("late_mn_resp_ready", mn_resp_ready, 1'b0);
      chk_bit("late_m0_resp_valid", m0_resp_valid, 1'b0);
      chk_bit("late_m1_resp_valid", m1_resp_valid, 1'b0);
      @(posedge clk);
      #1;
      mn_resp_valid = 1'b0;

      // Fixed priority: both masters always valid, m1 starves.
      f_m0_req_valid = 1'b1; f_m0_req = 32'h0000_AAAA;
      f_m1_req_valid = 1'b1; f_m1_req = 32'h8000_5555;
      f_mn_req_ready = 1'b1; f_m0_resp_ready = 1'b1; f_m1_resp_ready = 1'b1;
      f_mn_resp = 32'h0BAD_F00D;
      g0 = 0; g1 = 0; fpend = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (f_mn_resp_valid && f_mn_resp_ready) fpend = 1'b0;
         if (f_mn_req_valid && f_mn_req_ready) begin
            fpend = 1'b1;
            if (f_m0_req_ready) g0++;
            if (f_m1_req_ready) g1++;
            chk_w("fp_payload", f_mn_req, 32'h0000_AAAA);
         end
         @(posedge clk);
         #1;
         f_mn_resp_valid = fpend;
      end
      chk_w("fp_m0_grants", g0, 32'd20);
      chk_w("fp_m1_grants", g1, 32'd0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mem_noc_arb_2to1.md
MEM_NOC_ARB_2TO1 -- requirements
Module: mem_noc_arb_2to1

Interface
REQ-001 Parameter FIXED_PRIO, default 0, selects arbitration: 0 = round-robin, 1 = m0 always wins.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 m0_req_valid  input  1  master 0 (instruction port) request valid.
REQ-005 m0_req_ready  output  1  master 0 request accepted.
REQ-006 m0_req  input  $bits(mem_req_t)  master 0 request payload.
REQ-007 m0_resp_valid  output  1  response to master 0 valid.
REQ-008 m0_resp_ready  input  1  master 0 can take response.
REQ-009 m0_resp  output  $bits(mem_resp_t)  response payload to master 0.
REQ-010 m1_req_valid / m1_req_ready / m1_req / m1_resp_valid / m1_resp_ready / m1_resp: same directions and widths as REQ-004..009, for master 1 (data port).
REQ-011 mn_req_valid  output  1  merged request valid toward the mem NoC router master port.
REQ-012 mn_req_ready  input  1  router accepts merged request.
REQ-013 mn_req  output  $bits(mem_req_t)  merged request payload.
REQ-014 mn_resp_valid  input  1  router response valid.
REQ-015 mn_resp_ready  output  1  arbiter can take response.
REQ-016 mn_resp  input  $bits(mem_resp_t)  router response payload.

Function
REQ-017 Block SHALL merge two masters onto one mem NoC master port; at most one transaction outstanding; responses return in order to the granted master.
REQ-018 FSM states: ARB_REQ (no transaction outstanding), ARB_RESP (one outstanding); reset state ARB_REQ.
REQ-019 Registers: st, gnt_id (1 bit, owner of pending/outstanding transaction), gnt_lock (1 bit, request presented but not yet handshaked), rr_ptr (1 bit, master with priority next), all cleared to 0 on rst.
REQ-020 Selection when gnt_lock=0: only one valid -> that master; both valid -> FIXED_PRIO=1 gives m0, else master rr_ptr; neither -> no request.
REQ-021 When gnt_lock=1, selection SHALL be gnt_id regardless of other valid; mn_req_valid, once asserted, SHALL stay asserted with unchanged mn_req until mn_req_ready (no retraction, no master swap).
REQ-022 gnt_lock SHALL set when mn_req_valid=1 and mn_req_ready=0; clear on mn_req handshake; gnt_id SHALL load the selected master whenever mn_req_valid=1.
REQ-023 mn_req = selected master's m*_req; mn_req_valid SHALL NOT depend combinationally on mn_req_ready.
REQ-024 ARB_REQ: mn_req_valid = selected master valid; selected m*_req_ready = mn_req_ready; unselected m*_req_ready = 0.
REQ-025 ARB_RESP: mn_req_valid = selected valid AND response handshake this cycle (back-to-back issue); otherwise all m*_req_ready = 0.
REQ-026 Transitions: ARB_REQ -> ARB_RESP on mn_req handshake; ARB_RESP -> ARB_REQ on response handshake without simultaneous request handshake; else hold.
REQ-027 Outstanding owner (out_id, reset 0) SHALL load gnt_id on each mn_req handshake; responses route by out_id, not gnt_id.
REQ-028 Response path: m{out_id}_resp_valid = mn_resp_valid; other m*_resp_valid = 0; mn_resp_ready = m{out_id}_resp_ready; both m*_resp = mn_resp; combinational, zero latency.
REQ-029 mn_resp_valid in ARB_REQ SHALL be ignored (mn_resp_ready = 0, no m*_resp_valid).
REQ-030 rr_ptr SHALL update to ~(granted id) on each mn_req handshake; unchanged in FIXED_PRIO=1.
REQ-031 Request latency: handshake in same cycle as m*_req_valid when idle and router ready; no internal buffering.

Reset
REQ-032 While rst=1 at a clock edge: st=ARB_REQ, gnt_id=gnt_lock=rr_ptr=out_id=0; outputs then: mn_req_valid=0 unless a master is valid, mn_resp_ready=0, m*_resp_valid=0.
REQ-033 rst mid-transaction SHALL discard the outstanding owner; a late response after reset is dropped per REQ-029.

Verification
REQ-034 Both valid from idle, router ready, FIXED_PRIO=0 -> m0 granted cycle 0, m1 granted after m0 response, rr_ptr toggles 0->1->0.
REQ-035 m1 presented, mn_req_ready=0 for 3 cycles, m0 raises valid cycle 1 -> mn_req stays m1 payload all 4 cycles, m0_req_ready=0.
REQ-036 Response and new m0 request same cycle in ARB_RESP -> both handshake, st stays ARB_RESP, out_id=0.
REQ-037 m1 outstanding, m1_resp_ready=0 2 cycles -> mn_resp_ready=0, m0_resp_valid=0, no new request accepted.
REQ-038 FIXED_PRIO=1, both masters continuously valid -> m0 granted every transaction, m1 starved.
REQ-039 rst asserted in ARB_RESP, then mn_resp_valid=1 -> no m*_resp_valid, mn_resp_ready=0, st=ARB_REQ.
